// File: rtl/riscv_pkg.sv
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared constants and types for the RVC-aware fetch aligner.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int unsigned c_hw_w    = 16;
    localparam int unsigned c_word_w  = 32;
    localparam int unsigned c_buf_hw  = 4;

    // Low two bits of a halfword equal to this mark a 32-bit instruction.
    localparam logic [1:0]  c_rvc_noncomp = 2'b11;

    localparam logic [31:0] c_reset_pc = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_WAIT      = 2'd1,
        ST_WAIT_DROP = 2'd2
    } fa_state_e;

    function automatic logic is_compressed(input logic [c_hw_w-1:0] hw);
        return hw[1:0] != c_rvc_noncomp;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_aligner_if.sv
// ============================================================================
//  Module      : fetch_aligner_if
//  Description : Memory, pipeline and redirect signals of the fetch aligner.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_aligner_if #(
    parameter int XLEN = 32
);
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_valid;
    logic [31:0]     mem_rdata;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic            out_is_c;

    modport master (
        input  redirect, redirect_pc, mem_valid, mem_rdata, out_ready,
        output mem_req, mem_addr, out_valid, out_instr, out_pc, out_is_c
    );

    modport slave (
        output redirect, redirect_pc, mem_valid, mem_rdata, out_ready,
        input  mem_req, mem_addr, out_valid, out_instr, out_pc, out_is_c
    );

endinterface

`default_nettype wire

// File: rtl/fetch_align_buf.sv
// ============================================================================
//  Module      : fetch_align_buf
//  Description : Four-halfword shift buffer; consume shifts from the head,
//                append fills behind the surviving entries in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_align_buf
    import riscv_pkg::*;
(
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  flush,
    input  wire logic [1:0]            consume_n,
    input  wire logic [1:0]            append_n,
    input  wire logic [c_hw_w-1:0]     app_lo,
    input  wire logic [c_hw_w-1:0]     app_hi,
    output logic      [2*c_hw_w-1:0]   head,
    output logic      [2:0]            count
);

    localparam int unsigned c_buf_w = c_buf_hw * c_hw_w;

    logic [c_buf_w-1:0] data_q, data_d;
    logic [2:0]         count_q, count_d;
    logic [2:0]         w_kept;

    always_comb begin
        w_kept  = count_q - {1'b0, consume_n};
        data_d  = data_q >> {consume_n, 4'b0000};
        for (int i = 0; i < c_buf_hw; i++) begin
            if (append_n != 2'd0 && 3'(i) == w_kept)
                data_d[i*c_hw_w +: c_hw_w] = app_lo;
            if (append_n == 2'd2 && 3'(i) == w_kept + 3'd1)
                data_d[i*c_hw_w +: c_hw_w] = app_hi;
        end
        count_d = w_kept + {1'b0, append_n};
        if (flush) begin
            data_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign head  = data_q[2*c_hw_w-1:0];
    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_aligner.sv
// ============================================================================
//  Module      : fetch_aligner
//  Description : Fetches aligned words and emits 16/32-bit RVC-aware
//                instructions, with redirect and stale-response discard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_aligner
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(c_reset_pc)
) (
    input  wire logic          risc_clk,
    input  wire logic          rst,
    fetch_aligner_if.master    bus
);

    localparam logic [XLEN-1:0] c_pc_rst    = RESET_PC & ~XLEN'(1);
    localparam logic [XLEN-1:0] c_fetch_rst = RESET_PC & ~XLEN'(3);

    fa_state_e       state_q, state_d;
    logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
    logic [XLEN-1:0] head_pc_q, head_pc_d;
    logic            drop_low_q, drop_low_d;

    logic [2*c_hw_w-1:0] w_head;
    logic [2:0]          w_count;
    logic                w_head_c;
    logic                w_out_valid;
    logic                w_consume;
    logic [1:0]          w_consume_n;
    logic                w_mem_fire;
    logic [1:0]          w_append_n;
    logic [c_hw_w-1:0]   w_app_lo;
    logic [c_hw_w-1:0]   w_app_hi;
    logic                w_mem_req;

    assign w_head_c    = is_compressed(w_head[c_hw_w-1:0]);
    assign w_out_valid = (w_count >= 3'd1 && w_head_c) ||
                         (w_count >= 3'd2 && !w_head_c);
    assign w_consume   = w_out_valid && bus.out_ready && !bus.redirect;
    assign w_consume_n = !w_consume ? 2'd0 : (w_head_c ? 2'd1 : 2'd2);

    // A response landing in the redirect cycle belongs to the old stream.
    assign w_mem_fire  = (state_q == ST_WAIT) && bus.mem_valid && !bus.redirect;
    assign w_append_n  = !w_mem_fire ? 2'd0 : (drop_low_q ? 2'd1 : 2'd2);
    assign w_app_lo    = drop_low_q ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    assign w_app_hi    = bus.mem_rdata[31:16];

    // count<=2 leaves room for a full word even with no consume.
    assign w_mem_req   = (state_q == ST_FETCH) && (w_count <= 3'd2) &&
                         !bus.redirect && !rst;

    fetch_align_buf u_buf (
        .clk       (risc_clk),
        .rst       (rst),
        .flush     (bus.redirect),
        .consume_n (w_consume_n),
        .append_n  (w_append_n),
        .app_lo    (w_app_lo),
        .app_hi    (w_app_hi),
        .head      (w_head),
        .count     (w_count)
    );

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        head_pc_d    = head_pc_q;
        drop_low_d   = drop_low_q;
        if (bus.redirect) begin
            head_pc_d    = bus.redirect_pc & ~XLEN'(1);
            fetch_addr_d = bus.redirect_pc & ~XLEN'(3);
            drop_low_d   = bus.redirect_pc[1];
            state_d      = (state_q != ST_FETCH && !bus.mem_valid) ?
                           ST_WAIT_DROP : ST_FETCH;
        end else begin
            if (w_consume)
                head_pc_d = head_pc_q + (w_head_c ? XLEN'(2) : XLEN'(4));
            case (state_q)
                ST_FETCH: begin
                    if (w_mem_req)
                        state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.mem_valid) begin
                        fetch_addr_d = fetch_addr_q + XLEN'(4);
                        drop_low_d   = 1'b0;
                        state_d      = ST_FETCH;
                    end
                end
                ST_WAIT_DROP: begin
                    if (bus.mem_valid)
                        state_d = ST_FETCH;
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge risc_clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            fetch_addr_q <= c_fetch_rst;
            head_pc_q    <= c_pc_rst;
            drop_low_q   <= RESET_PC[1];
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            head_pc_q    <= head_pc_d;
            drop_low_q   <= drop_low_d;
        end
    end

    assign bus.mem_req   = w_mem_req;
    assign bus.mem_addr  = fetch_addr_q;
    assign bus.out_valid = w_out_valid;
    assign bus.out_instr = w_head_c ? XLEN'(w_head[c_hw_w-1:0]) : XLEN'(w_head);
    assign bus.out_pc    = head_pc_q;
    assign bus.out_is_c  = w_out_valid && w_head_c;

endmodule

`default_nettype wire

// File: tb/tb_fetch_aligner.sv
// ============================================================================
//  Module      : tb_fetch_aligner
//  Description : Directed self-checking bench for fetch_aligner.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_aligner;

    logic risc_clk = 1'b0;
    logic rst      = 1'b1;

    fetch_aligner_if #(.XLEN(32)) bus ();

    fetch_aligner #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .risc_clk (risc_clk),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 risc_clk = ~risc_clk;

    logic [31:0] img [0:255];
    int          mem_lat = 1;
    bit          pend;
    logic [31:0] paddr;
    int          cnt;
    logic [31:0] req_q [$];
    logic [31:0] got_pc [$];
    logic [31:0] got_instr [$];
    logic        got_c [$];
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [15:0] hw(input int k);
        return 16'h4001 | 16'(k << 2);
    endfunction

    // Memory responder: response at negedge+1, request sampled at negedge+3.
    initial begin
        bus.mem_valid = 1'b0;
        bus.mem_rdata = 32'h0;
        pend = 1'b0;
        forever begin
            @(negedge risc_clk);
            #1;
            bus.mem_valid = 1'b0;
            bus.mem_rdata = 32'h0;
            if (rst) pend = 1'b0;
            else if (pend) begin
                if (cnt == 0) begin
                    bus.mem_valid = 1'b1;
                    bus.mem_rdata = img[paddr[9:2]];
                    pend = 1'b0;
                end else cnt--;
            end
            #2;
            if (!rst && bus.mem_req) begin
                check_eq("mem_addr_align", {30'b0, bus.mem_addr[1:0]}, 32'h0);
                pend  = 1'b1;
                paddr = bus.mem_addr;
                cnt   = mem_lat - 1;
                req_q.push_back(bus.mem_addr);
            end
        end
    end

    // Handshake monitor.
    initial forever begin
        @(negedge risc_clk);
        #3;
        if (!rst && bus.out_valid && bus.out_ready && !bus.redirect) begin
            got_pc.push_back(bus.out_pc);
            got_instr.push_back(bus.out_instr);
            got_c.push_back(bus.out_is_c);
        end
    end

    task automatic step();
        @(negedge risc_clk);
        #2;
    endtask

    task automatic clear_q();
        got_pc.delete();
        got_instr.delete();
        got_c.delete();
        req_q.delete();
    endtask

    task automatic do_reset(input int kind, input logic rdy);
        rst = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.out_ready   = rdy;
        mem_lat = 1;
        for (int i = 0; i < 256; i++)
            img[i] = (kind == 0) ? 32'h0001_0001 : {hw(2*i+1), hw(2*i)};
        step();
        step();
        clear_q();
        rst = 1'b0;
    endtask

    task automatic wait_outs(input int n);
        for (int i = 0; i < 300; i++) begin
            if (got_pc.size() >= n) return;
            step();
        end
        check_eq("wait_outs_timeout", got_pc.size(), n);
    endtask

    task automatic chk_out(input int idx, input logic [31:0] pc, input logic [31:0] ins, input logic c);
        if (idx < got_pc.size()) begin
            check_eq($sformatf("out%0d_pc", idx), got_pc[idx], pc);
            check_eq($sformatf("out%0d_instr", idx), got_instr[idx], ins);
            check_eq($sformatf("out%0d_is_c", idx), got_c[idx], c);
        end else check_eq("out_missing", got_pc.size(), idx + 1);
    endtask

    task automatic chk_req0(input logic [31:0] addr);
        if (req_q.size() > 0) check_eq("first_req_addr", req_q[0], addr);
        else check_eq("req_missing", req_q.size(), 1);
    endtask

    initial begin
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.out_ready   = 1'b1;

        // Reset state
        step();
        step();
        check_eq("rst_mem_req",   bus.mem_req,   32'h0);
        check_eq("rst_out_valid", bus.out_valid, 32'h0);
        check_eq("rst_out_instr", bus.out_instr, 32'h0);
        check_eq("rst_out_pc",    bus.out_pc,    32'h0);
        check_eq("rst_out_is_c",  bus.out_is_c,  32'h0);

        // 1: 32-bit followed by two compressed
        do_reset(0, 1'b1);
        img[0] = 32'h00A0_0093;
        img[1] = 32'h4501_4581;
        #1;
        check_eq("t1_first_req",  bus.mem_req,  32'h1);
        check_eq("t1_first_addr", bus.mem_addr, 32'h0);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin
                step();
                seen = bus.mem_valid;
            end
            check_eq("t1_mem_valid_seen", seen, 32'h1);
        end
        step();
        check_eq("t1_lat_valid", bus.out_valid, 32'h1);
        check_eq("t1_lat_pc",    bus.out_pc,    32'h0);
        check_eq("t1_lat_instr", bus.out_instr, 32'h00A0_0093);
        wait_outs(3);
        chk_out(0, 32'h0, 32'h00A0_0093, 1'b0);
        chk_out(1, 32'h4, 32'h0000_4581, 1'b1);
        chk_out(2, 32'h6, 32'h0000_4501, 1'b1);

        // 2: 32-bit instruction straddling two words
        do_reset(0, 1'b1);
        img[0] = 32'h0093_4581;
        img[1] = 32'h0000_00A0;
        mem_lat = 4;
        wait_outs(1);
        check_eq("t2_straddle_hold", bus.out_valid, 32'h0);
        wait_outs(3);
        chk_out(0, 32'h0, 32'h0000_4581, 1'b1);
        chk_out(1, 32'h2, 32'h00A0_0093, 1'b0);
        chk_out(2, 32'h6, 32'h0000_0000, 1'b1);

        // 3: redirect with a request outstanding
        do_reset(0, 1'b1);
        img[2]  = 32'h4AA5_4AA1;
        img[64] = 32'h4581_4A01;
        img[65] = 32'h0001_0001;
        mem_lat = 4;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                step();
                seen = bus.mem_req && bus.mem_addr == 32'h8;
            end
            check_eq("t3_req8_seen", seen, 32'h1);
        end
        step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h102;
        clear_q();
        step();
        bus.redirect = 1'b0;
        #1;
        check_eq("t3_drop_no_req", bus.mem_req, 32'h0);
        wait_outs(2);
        chk_req0(32'h100);
        chk_out(0, 32'h102, 32'h0000_4581, 1'b1);
        chk_out(1, 32'h104, 32'h0000_0001, 1'b1);

        // 4: stall with a compressed stream
        do_reset(1, 1'b0);
        for (int i = 0; i < 10; i++) step();
        check_eq("t4_req_off",    bus.mem_req,   32'h0);
        check_eq("t4_req_count",  req_q.size(),  32'd2);
        check_eq("t4_hold_valid", bus.out_valid, 32'h1);
        check_eq("t4_hold_pc",    bus.out_pc,    32'h0);
        check_eq("t4_hold_instr", bus.out_instr, {16'h0, hw(0)});
        check_eq("t4_no_out",     got_pc.size(), 32'd0);
        bus.out_ready = 1'b1;
        wait_outs(6);
        for (int k = 0; k < 6; k++)
            chk_out(k, 32'(2*k), {16'h0, hw(k)}, 1'b1);

        // 5: redirect coinciding with mem_valid and a handshake
        do_reset(1, 1'b1);
        img[64] = 32'h4105_4101;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin
                step();
                seen = bus.mem_valid && bus.out_valid;
            end
            check_eq("t5_sync_seen", seen, 32'h1);
        end
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        clear_q();
        step();
        bus.redirect = 1'b0;
        #1;
        check_eq("t5_restart_req",  bus.mem_req,  32'h1);
        check_eq("t5_restart_addr", bus.mem_addr, 32'h100);
        wait_outs(2);
        chk_out(0, 32'h100, 32'h0000_4101, 1'b1);
        chk_out(1, 32'h102, 32'h0000_4105, 1'b1);

        // 6: asynchronous reset pulse mid-WAIT
        do_reset(1, 1'b1);
        mem_lat = 4;
        wait_outs(2);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin
                step();
                seen = bus.mem_req;
            end
            check_eq("t6_req_seen", seen, 32'h1);
        end
        step();
        rst = 1'b1;
        #1;
        check_eq("t6_async_mem_req",   bus.mem_req,   32'h0);
        check_eq("t6_async_out_valid", bus.out_valid, 32'h0);
        check_eq("t6_async_out_pc",    bus.out_pc,    32'h0);
        check_eq("t6_async_out_instr", bus.out_instr, 32'h0);
        check_eq("t6_async_out_is_c",  bus.out_is_c,  32'h0);
        #9;
        clear_q();
        rst = 1'b0;
        wait_outs(2);
        chk_req0(32'h0);
        chk_out(0, 32'h0, {16'h0, hw(0)}, 1'b1);
        chk_out(1, 32'h2, {16'h0, hw(1)}, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_aligner.md
Name: fetch_aligner

Overview:
- Sits between instruction memory and the IF/ID stage of the pipelined core, which supports the compressed (RVC) instruction extension.
- Memory is the responder: the block requests aligned 32-bit words, one outstanding at a time.
- The pipeline is the consumer: the block emits one instruction per handshake, either a 16-bit compressed instruction or a 32-bit instruction that may straddle two words.
- It handles branch/jump redirects to any halfword address and discards stale data.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (bit 0 ignored).
XLEN, 32, address and instruction width.

Ports:
risc_clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset, asynchronous, active-high.
redirect  in  1  pipeline flush: restart fetch at redirect_pc.
redirect_pc  in  XLEN  target address; bit 0 ignored, bit 1 selects the starting halfword.
mem_req  out  1  request a word at mem_addr.
mem_addr  out  XLEN  word-aligned address; bits [1:0] always 0.
mem_valid  in  1  response strobe, exactly one per accepted request, at least 1 cycle after the request.
mem_rdata  in  32  response word, little-endian halfwords.
out_valid  out  1  out_instr/out_pc valid.
out_ready  in  1  pipeline accepts the instruction (low = stall).
out_instr  out  XLEN  instruction; a compressed instruction is zero-extended in [15:0].
out_pc  out  XLEN  address of out_instr.
out_is_c  out  1  1 = 16-bit instruction.

Behaviour:
- Reset values:
  - buffer empty (count=0).
  - state=FETCH, fetch_addr=RESET_PC&~3, head_pc=RESET_PC&~1.
  - drop_low=RESET_PC[1].
  - mem_req=0 while rst=1.
  - out_valid=0, out_instr=0, out_pc=RESET_PC&~1, out_is_c=0.
- Buffer:
  - 4 halfwords (64 bits) with count 0..4.
  - Head halfword at the lowest position.
  - Head is compressed iff head[1:0] != 2'b11.
- out_valid is combinational:
  - count>=1 and head compressed, or
  - count>=2 and head not compressed.
- out_instr is taken from the buffer head; out_pc = head_pc.
- Consume on out_valid & out_ready & !redirect:
  - shift out 1 halfword (C) or 2 halfwords (32-bit).
  - head_pc += 2 or 4.
- FSM states:
  - FETCH: mem_req = (count<=2) & !redirect, mem_addr=fetch_addr. On request go to WAIT.
  - WAIT: mem_req=0. On mem_valid:
    - append the word's halfwords, or only the upper halfword if drop_low=1, then clear drop_low.
    - fetch_addr += 4, go to FETCH.
    - a same-cycle consume and append are both applied; the count arithmetic must never exceed 4. This is guaranteed by the count<=2 request rule.
  - WAIT_DROP: mem_req=0. On mem_valid, discard the data and go to FETCH.
- Redirect (highest priority, any state):
  - next edge: count=0, head_pc=redirect_pc&~1, fetch_addr=redirect_pc&~3, drop_low=redirect_pc[1].
  - state goes to WAIT_DROP if a request is outstanding and its mem_valid is not in this same cycle; otherwise FETCH.
  - mem_valid in the redirect cycle is discarded.
  - a consume in the redirect cycle is ignored.
  - redirect while in WAIT_DROP stays in WAIT_DROP.
- Latency:
  - redirect at edge N → mem_req high in cycle N+1 (no outstanding request).
  - mem_valid at edge M → out_valid in cycle M+1.
- A 32-bit instruction straddling a word boundary (lower half in slot 1 of word k) emits only after word k+1 arrives.
- fetch_addr wraps modulo 2^XLEN; no error.
- Reset asserted mid-transaction returns all state to reset values immediately. A late mem_valid is not tracked after reset; memory is reset by the same rst.

Decomposition:
- Shared package riscv_pkg holds:
  - RVC quadrant constant (2'b11 = non-compressed).
  - halfword/word width localparams.
  - RESET_PC default.
- One sub-module, fetch_align_buf: the 4-halfword shift buffer with count and append/consume ports.
- The FSM and PC tracking stay in fetch_aligner.

Test Plan:
1. Reset at RESET_PC=0, memory returns 0x00A00093 (addi), then 0x4501_4581 (c.li a1,0 / c.li a0,0) → outputs: pc 0 32-bit 0x00A00093; pc 4 C 0x4581; pc 6 C 0x4501.
2. Straddle: word0=0x0093_4581, word1=0x0000_00A0 → pc 0 C 0x4581, then pc 2 32-bit 0x00A00093, emitted only after word1 arrives.
3. Redirect to 0x102 with a request to 0x8 outstanding → the 0x8 response is discarded; next mem_addr=0x100; the low halfword is dropped; the first out_pc=0x102.
4. Stall: out_ready=0 for 10 cycles with a stream of C instructions → mem_req deasserts once count>2; there is no overflow, and the instruction order is preserved after release.
5. Redirect in the same cycle as mem_valid and out_valid&out_ready → data is discarded, no consume occurs, and fetch restarts at the target.
6. rst pulsed 10 ns mid-WAIT, asynchronously to risc_clk → outputs return to reset values immediately and fetching restarts from RESET_PC.
